br_flow_demux_multihot_buffered: RTL and testbench
==================================================

BR_FLOW_DEMUX_MULTIHOT_BUFFERED -- requirements
Module: br_flow_demux_multihot_buffered

Interface
REQ-001 Parameter NumFlows, default 2: number of pop flows; SHALL be >= 2 (static assert).
REQ-002 Parameter Width, default 1: payload bits; SHALL be >= 1 (static assert).
REQ-003 Parameter Depth, default 2: entries per flow buffer; SHALL be >= 1 (static assert).
REQ-004 Parameter DropEmptySelect, default 1: 1 = push with all-zero select is accepted and discarded; 0 = an all-zero select with push_valid=1 is an assertion failure.
REQ-005 Port clk, input, 1: sole clock; all state on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port multihot_select, input, NumFlows: destination flows for the current push beat.
REQ-008 Port push_ready, output, 1: push beat accepted when push_valid && push_ready.
REQ-009 Port push_valid, input, 1: push beat present.
REQ-010 Port push_data, input, Width: push payload.
REQ-011 Port pop_ready, input, NumFlows: per-flow consumer ready.
REQ-012 Port pop_valid, output, NumFlows: per-flow valid; registered, stable under backpressure.
REQ-013 Port pop_data, output, NumFlows x Width: per-flow payload; registered, stable under backpressure.
REQ-014 Port pop_count, output, NumFlows x $clog2(Depth+1): per-flow buffer occupancy.

Function
REQ-015 Each flow i SHALL own an independent FIFO of Depth entries holding push_data copies.
REQ-016 space_i SHALL be (count_i < Depth) || (pop_valid[i] && pop_ready[i]).
REQ-017 push_ready SHALL equal AND over i of (!multihot_select[i] || space_i); all-zero select gives push_ready=1.
REQ-018 On push beat, push_data SHALL be written to every flow i with multihot_select[i]=1, in the same cycle, atomically; no partial delivery.
REQ-019 push_ready SHALL be independent of push_valid (no valid-to-ready combinational path).
REQ-020 Latency push-to-pop SHALL be 1 cycle: a beat written at edge N is visible on pop_valid/pop_data after edge N.
REQ-021 pop_valid[i] SHALL equal (count_i != 0); pop_data[i] SHALL be the oldest entry of flow i.
REQ-022 Pop on flow i SHALL occur when pop_valid[i] && pop_ready[i]; flows drain independently, order preserved per flow.
REQ-023 Simultaneous push and pop on a full flow (count_i=Depth) SHALL be allowed; count_i unchanged.
REQ-024 count_i SHALL update as +1 on write only, -1 on pop only, unchanged on both or neither; never exceeds Depth, never underflows.
REQ-025 Read/write pointers SHALL wrap modulo Depth (non-power-of-two Depth supported).
REQ-026 Once pop_valid[i]=1, pop_valid[i] and pop_data[i] SHALL hold until popped, regardless of multihot_select, push_valid, or push_data changes (implementation assertion).
REQ-027 With DropEmptySelect=1, a push beat with select=0 SHALL alter no state.
REQ-028 Integration assertions: push_valid and push_data stable while push_valid && !push_ready; multihot_select stable under the same condition; no X on multihot_select when push_valid=1.
REQ-029 Final-state assertion: all pop_valid = 0 at end of test.

Reset
REQ-030 While rst_n=0, all count_i, read/write pointers SHALL be 0; pop_valid = 0, pop_count = 0, asynchronously on assertion.
REQ-031 Buffer storage SHALL not be reset; pop_data is don't-care while pop_valid[i]=0.
REQ-032 push_ready during reset SHALL evaluate per REQ-017 with empty buffers; bench SHALL not push during reset.
REQ-033 Reset asserted mid-operation SHALL discard all buffered beats; first post-reset push behaves as from empty.
REQ-034 Deassertion of rst_n SHALL be synchronised externally; block adds no synchronizer.

Verification
REQ-035 NumFlows=3, Depth=2: push 0xA select 3'b101, all pop_ready=1 -> next cycle pop_valid=3'b101, pop_data[0]=pop_data[2]=0xA, pop_valid[1]=0.
REQ-036 Depth=2, pop_ready[1]=0: push 0x1,0x2 select 3'b011, then 0x3 select 3'b011 -> push_ready=0 on third beat; flow 0 drains 0x1,0x2; after pop_ready[1]=1 pops 0x1 same cycle, 0x3 accepted that cycle.
REQ-037 Backpressure stability: flow 2 holds 0x5 with pop_ready[2]=0 while select toggles randomly for 10 cycles -> pop_valid[2]=1, pop_data[2]=0x5 unchanged throughout.
REQ-038 Depth=3 (non-power-of-two): 20 beats select all-ones, random pop_ready per flow -> each flow emits 20 beats in push order, pop_count never > 3.
REQ-039 DropEmptySelect=1: push 0x7 select 0 -> push_ready=1, no pop_valid next cycle, counts unchanged.
REQ-040 Reset mid-stream: flows hold counts {2,1,0}; drop rst_n for 1 cycle -> pop_valid=0 and pop_count=0 immediately; next push 0x9 select 3'b111 appears on all flows one cycle later.

Source files
------------

// File: rtl/br_flow_demux_multihot_buffered.sv
// Multicast demux: one push beat is copied atomically into every selected
// per-flow FIFO; each flow drains independently from registered outputs.
module br_flow_demux_multihot_buffered #(
    parameter int NumFlows        = 2,
    parameter int Width           = 1,
    parameter int Depth           = 2,
    parameter bit DropEmptySelect = 1
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [NumFlows-1:0]                                multihot_select,
    output logic                                               push_ready,
    input  logic                                               push_valid,
    input  logic [Width-1:0]                                   push_data,
    input  logic [NumFlows-1:0]                                pop_ready,
    output logic [NumFlows-1:0]                                pop_valid,
    output logic [NumFlows-1:0][Width-1:0]                     pop_data,
    output logic [NumFlows-1:0][$clog2(Depth+1)-1:0]           pop_count
);

    localparam int CountWidth = $clog2(Depth + 1);
    localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);
    localparam logic [PtrWidth-1:0]   LastPtr    = PtrWidth'(Depth - 1);

    if (NumFlows < 2) begin : g_bad_num_flows
        $error("NumFlows must be >= 2");
    end
    if (Width < 1) begin : g_bad_width
        $error("Width must be >= 1");
    end
    if (Depth < 1) begin : g_bad_depth
        $error("Depth must be >= 1");
    end

    logic [NumFlows-1:0] space;
    logic [NumFlows-1:0] wr_en;
    logic [NumFlows-1:0] rd_en;
    logic                push_fire;

    // Ready depends only on select and pop-side state, never on push_valid.
    assign push_ready = &(~multihot_select | space);
    assign push_fire  = push_valid & push_ready;

    for (genvar i = 0; i < NumFlows; i++) begin : g_flow
        logic [Depth-1:0][Width-1:0] mem;
        logic [PtrWidth-1:0]         wr_ptr;
        logic [PtrWidth-1:0]         rd_ptr;
        logic [CountWidth-1:0]       count;

        assign rd_en[i] = pop_valid[i] & pop_ready[i];
        assign space[i] = (count < DepthCount) | rd_en[i];
        assign wr_en[i] = push_fire & multihot_select[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en[i]) begin
                    wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
                end
                if (rd_en[i]) begin
                    rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
                end
                case ({wr_en[i], rd_en[i]})
                    2'b10:   count <= count + CountWidth'(1);
                    2'b01:   count <= count - CountWidth'(1);
                    default: count <= count;
                endcase
            end
        end

        // Storage is deliberately unreset; pop_valid gates its contents.
        always_ff @(posedge clk) begin
            if (wr_en[i]) begin
                mem[wr_ptr] <= push_data;
            end
        end

        assign pop_valid[i] = (count != '0);
        assign pop_data[i]  = mem[rd_ptr];
        assign pop_count[i] = count;

`ifndef SYNTHESIS
        a_pop_hold: assert property (@(posedge clk) disable iff (!rst_n)
            pop_valid[i] && !pop_ready[i]
            |=> pop_valid[i] && $stable(pop_data[i]));
        a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
            count <= DepthCount);
`endif
    end

`ifndef SYNTHESIS
    a_push_stable: assert property (@(posedge clk) disable iff (!rst_n)
        push_valid && !push_ready
        |=> push_valid && $stable(push_data) && $stable(multihot_select));
    a_select_known: assert property (@(posedge clk) disable iff (!rst_n)
        push_valid |-> !$isunknown(multihot_select));
    if (!DropEmptySelect) begin : g_no_empty_select
        a_select_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
            push_valid |-> |multihot_select);
    end
`endif

endmodule

// File: tb/tb_br_flow_demux_multihot_buffered.sv
// Directed bench: Depth=2 instance for multicast/backpressure/reset,
// Depth=3 instance for pointer wrap ordering.
module tb_br_flow_demux_multihot_buffered;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;

    logic [2:0]      sel = '0;
    logic            push_ready;
    logic            push_valid = 1'b0;
    logic [7:0]      push_data = '0;
    logic [2:0]      pop_ready = '0;
    logic [2:0]      pop_valid;
    logic [2:0][7:0] pop_data;
    logic [2:0][1:0] pop_count;

    logic [2:0]      sel3 = '0;
    logic            push_ready3;
    logic            push_valid3 = 1'b0;
    logic [7:0]      push_data3 = '0;
    logic [2:0]      pop_ready3 = '0;
    logic [2:0]      pop_valid3;
    logic [2:0][7:0] pop_data3;
    logic [2:0][1:0] pop_count3;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    br_flow_demux_multihot_buffered #(
        .NumFlows(3), .Width(8), .Depth(2), .DropEmptySelect(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .multihot_select(sel), .push_ready(push_ready),
        .push_valid(push_valid), .push_data(push_data),
        .pop_ready(pop_ready), .pop_valid(pop_valid),
        .pop_data(pop_data), .pop_count(pop_count)
    );

    br_flow_demux_multihot_buffered #(
        .NumFlows(3), .Width(8), .Depth(3), .DropEmptySelect(1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .multihot_select(sel3), .push_ready(push_ready3),
        .push_valid(push_valid3), .push_data(push_data3),
        .pop_ready(pop_ready3), .pop_valid(pop_valid3),
        .pop_data(pop_data3), .pop_count(pop_count3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        sel = 3'b111;
        #1;
        total++;
        if (pop_valid !== 3'b000)
            $display("FAIL reset_valid: got %b expected 000", pop_valid);
        else pass_cnt++;
        total++;
        if (pop_count !== 6'd0)
            $display("FAIL reset_count: got %h expected 0", pop_count);
        else pass_cnt++;
        total++;
        if (push_ready !== 1'b1)
            $display("FAIL reset_ready: got %b expected 1", push_ready);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        sel = '0;
        step();
    endtask

    task automatic test_multicast;
        pop_ready = 3'b111;
        sel = 3'b101;
        push_data = 8'h0A;
        push_valid = 1'b1;
        #1;
        total++;
        if (push_ready !== 1'b1)
            $display("FAIL mc_ready: got %b expected 1", push_ready);
        else pass_cnt++;
        step();
        push_valid = 1'b0;
        sel = '0;
        total++;
        if (pop_valid !== 3'b101)
            $display("FAIL mc_valid: got %b expected 101", pop_valid);
        else pass_cnt++;
        total++;
        if (pop_data[0] !== 8'h0A || pop_data[2] !== 8'h0A)
            $display("FAIL mc_data: got %h/%h expected 0a/0a",
                     pop_data[0], pop_data[2]);
        else pass_cnt++;
        step();
        total++;
        if (pop_valid !== 3'b000)
            $display("FAIL mc_drain: got %b expected 000", pop_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        pop_ready = 3'b101;
        sel = 3'b011;
        push_valid = 1'b1;
        push_data = 8'h01;
        step();
        push_data = 8'h02;
        total++;
        if (pop_data[0] !== 8'h01)
            $display("FAIL bp_f0_first: got %h expected 01", pop_data[0]);
        else pass_cnt++;
        step();
        push_data = 8'h03;
        #1;
        total++;
        if (push_ready !== 1'b0)
            $display("FAIL bp_ready_low: got %b expected 0", push_ready);
        else pass_cnt++;
        total++;
        if (pop_data[0] !== 8'h02 || pop_count[1] !== 2'd2)
            $display("FAIL bp_f0_second: got %h cnt1 %0d expected 02 cnt1 2",
                     pop_data[0], pop_count[1]);
        else pass_cnt++;
        step();
        total++;
        if (push_ready !== 1'b0 || pop_valid[0] !== 1'b0)
            $display("FAIL bp_hold: got ready %b v0 %b expected 0 0",
                     push_ready, pop_valid[0]);
        else pass_cnt++;
        pop_ready = 3'b111;
        #1;
        total++;
        if (push_ready !== 1'b1 || pop_data[1] !== 8'h01)
            $display("FAIL bp_release: got ready %b d1 %h expected 1 01",
                     push_ready, pop_data[1]);
        else pass_cnt++;
        step();
        push_valid = 1'b0;
        sel = '0;
        total++;
        if (pop_count[1] !== 2'd2 || pop_data[1] !== 8'h02 ||
            pop_data[0] !== 8'h03)
            $display("FAIL bp_after: got cnt1 %0d d1 %h d0 %h expected 2 02 03",
                     pop_count[1], pop_data[1], pop_data[0]);
        else pass_cnt++;
        step();
        total++;
        if (pop_data[1] !== 8'h03 || pop_valid !== 3'b010)
            $display("FAIL bp_last: got d1 %h v %b expected 03 010",
                     pop_data[1], pop_valid);
        else pass_cnt++;
        step();
        total++;
        if (pop_valid !== 3'b000)
            $display("FAIL bp_empty: got %b expected 000", pop_valid);
        else pass_cnt++;
    endtask

    task automatic test_hold;
        pop_ready = 3'b000;
        sel = 3'b100;
        push_data = 8'h05;
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sel = 3'($urandom);
            push_data = 8'($urandom);
            step();
            total++;
            if (pop_valid[2] !== 1'b1 || pop_data[2] !== 8'h05)
                $display("FAIL hold_%0d: got v %b d %h expected 1 05",
                         k, pop_valid[2], pop_data[2]);
            else pass_cnt++;
        end
        sel = '0;
        pop_ready = 3'b111;
        step();
        total++;
        if (pop_valid !== 3'b000)
            $display("FAIL hold_drain: got %b expected 000", pop_valid);
        else pass_cnt++;
    endtask

    task automatic test_drop_empty;
        sel = 3'b000;
        push_data = 8'h07;
        push_valid = 1'b1;
        #1;
        total++;
        if (push_ready !== 1'b1)
            $display("FAIL drop_ready: got %b expected 1", push_ready);
        else pass_cnt++;
        step();
        push_valid = 1'b0;
        total++;
        if (pop_valid !== 3'b000 || pop_count !== 6'd0)
            $display("FAIL drop_state: got v %b cnt %h expected 000 0",
                     pop_valid, pop_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        pop_ready = 3'b000;
        sel = 3'b011;
        push_data = 8'h01;
        push_valid = 1'b1;
        step();
        sel = 3'b001;
        push_data = 8'h02;
        step();
        push_valid = 1'b0;
        sel = '0;
        total++;
        if (pop_count[0] !== 2'd2 || pop_count[1] !== 2'd1 ||
            pop_count[2] !== 2'd0)
            $display("FAIL rm_pre: got %0d %0d %0d expected 2 1 0",
                     pop_count[0], pop_count[1], pop_count[2]);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++;
        if (pop_valid !== 3'b000 || pop_count !== 6'd0)
            $display("FAIL rm_async: got v %b cnt %h expected 000 0",
                     pop_valid, pop_count);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        pop_ready = 3'b111;
        sel = 3'b111;
        push_data = 8'h09;
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        sel = '0;
        total++;
        if (pop_valid !== 3'b111 || pop_data[0] !== 8'h09 ||
            pop_data[1] !== 8'h09 || pop_data[2] !== 8'h09)
            $display("FAIL rm_post: got v %b d %h expected 111 090909",
                     pop_valid, pop_data);
        else pass_cnt++;
        step();
    endtask

    task automatic test_depth3_wrap;
        int sent;
        int cycles;
        int got [3];
        sent = 0;
        cycles = 0;
        got = '{0, 0, 0};
        sel3 = 3'b111;
        while ((sent < 20 || got[0] < 20 || got[1] < 20 || got[2] < 20) &&
               cycles < 600) begin
            push_valid3 = (sent < 20);
            push_data3 = 8'(8'h10 + sent);
            pop_ready3 = 3'($urandom);
            #1;
            for (int f = 0; f < 3; f++) begin
                total++;
                if (pop_count3[f] > 2'd3)
                    $display("FAIL d3_count_f%0d: got %0d expected <= 3",
                             f, pop_count3[f]);
                else pass_cnt++;
                if (pop_valid3[f] && pop_ready3[f]) begin
                    total++;
                    if (pop_data3[f] !== 8'(8'h10 + got[f]))
                        $display("FAIL d3_order_f%0d: got %h expected %h",
                                 f, pop_data3[f], 8'(8'h10 + got[f]));
                    else pass_cnt++;
                    got[f]++;
                end
            end
            if (push_valid3 && push_ready3) sent++;
            step();
            cycles++;
        end
        push_valid3 = 1'b0;
        sel3 = '0;
        pop_ready3 = 3'b111;
        for (int f = 0; f < 3; f++) begin
            total++;
            if (got[f] != 20 || sent != 20)
                $display("FAIL d3_total_f%0d: got %0d popped %0d pushed expected 20 20",
                         f, got[f], sent);
            else pass_cnt++;
        end
        step();
    endtask

    task automatic test_final_empty;
        step();
        total++;
        if (pop_valid !== 3'b000 || pop_valid3 !== 3'b000)
            $display("FAIL final_empty: got %b/%b expected 000/000",
                     pop_valid, pop_valid3);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_multicast();
        test_backpressure();
        test_hold();
        test_drop_empty();
        test_reset_mid();
        test_depth3_wrap();
        test_final_empty();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
